// File: rtl/adc_chan_avg_if.sv
// Sample-in / average-out bundle between adc_controller, the averager and the PID stage.
// The averager takes the slave view; the sample source and result sink share the master view.
interface adc_chan_avg_if #(
    parameter int W_DATA      = 18,
    parameter int N_CHAN      = 6,
    parameter int AVG_MAX_LOG = 7
);
    localparam int W_CH  = $clog2(N_CHAN);
    localparam int W_LOG = $clog2(AVG_MAX_LOG + 1);

    logic [N_CHAN-1:0] data_valid_in;
    logic [W_DATA-1:0] data_a_in;
    logic [W_DATA-1:0] data_b_in;
    logic [W_LOG-1:0]  avg_log_in;
    logic              update_in;
    logic [W_DATA-1:0] data_out;
    logic [W_CH-1:0]   chan_out;
    logic              data_valid_out;
    logic              overflow_out;

    modport master (
        output data_valid_in, data_a_in, data_b_in, avg_log_in, update_in,
        input  data_out, chan_out, data_valid_out, overflow_out
    );

    modport slave (
        input  data_valid_in, data_a_in, data_b_in, avg_log_in, update_in,
        output data_out, chan_out, data_valid_out, overflow_out
    );
endinterface

// File: rtl/adc_chan_avg.sv
// Per-channel 2^N boxcar decimator, six channels muxed onto one result stream.
// Latency: 1 cycle after the completing strobe; a B result colliding with an A result waits 1 more.
// No backpressure: one pending slot absorbs A/B collisions, further losers are dropped (sticky overflow).
module adc_chan_avg #(
    parameter int W_DATA      = 18,
    parameter int N_CHAN      = 6,
    parameter int AVG_MAX_LOG = 7
) (
    input  logic          clk_in,
    input  logic          reset_in,
    adc_chan_avg_if.slave bus
);
    localparam int W_ACC = W_DATA + AVG_MAX_LOG;
    localparam int HALF  = N_CHAN / 2;
    localparam int W_CH  = $clog2(N_CHAN);
    localparam int W_LOG = $clog2(AVG_MAX_LOG + 1);

    typedef enum logic {IDLE, PEND} state_t;
    state_t state, state_nxt;

    logic [W_LOG-1:0]        avg_log;
    logic [AVG_MAX_LOG-1:0]  cnt_last;
    logic signed [W_ACC-1:0] acc [N_CHAN];
    logic [AVG_MAX_LOG-1:0]  cnt [N_CHAN];
    logic signed [W_ACC-1:0] sum [N_CHAN];
    logic [W_DATA-1:0]       res [N_CHAN];

    logic [HALF-1:0]         raw_a, raw_b;
    logic [N_CHAN-1:0]       stb, done;
    logic                    done_a, done_b;
    logic [W_DATA-1:0]       res_a, res_b;
    logic [W_CH-1:0]         chan_a, chan_b;

    logic [W_DATA-1:0]       pend_dat, out_dat, ld_dat, data_q;
    logic [W_CH-1:0]         pend_chan, out_chan, ld_chan, chan_q;
    logic                    out_vld, ld_pend, drop, valid_q, ovf_q;

    assign cnt_last = AVG_MAX_LOG'((32'd1 << avg_log) - 32'd1);

    // A malformed multi-bit strobe keeps only the lowest set bit of each bus half.
    assign raw_a = bus.data_valid_in[HALF-1:0];
    assign raw_b = bus.data_valid_in[N_CHAN-1:HALF];
    assign stb   = {raw_b & (~raw_b + HALF'(1)), raw_a & (~raw_a + HALF'(1))};

    for (genvar c = 0; c < N_CHAN; c++) begin : g_ch
        logic [W_DATA-1:0] smp;
        assign smp    = (c < HALF) ? bus.data_a_in : bus.data_b_in;
        assign sum[c] = acc[c] + {{AVG_MAX_LOG{smp[W_DATA-1]}}, smp};
        assign res[c] = W_DATA'(sum[c] >>> avg_log);
        assign done[c] = stb[c] && !bus.update_in && (cnt[c] == cnt_last);
    end

    assign done_a = |done[HALF-1:0];
    assign done_b = |done[N_CHAN-1:HALF];

    always_comb begin
        res_a  = res[0];
        chan_a = '0;
        res_b  = res[HALF];
        chan_b = W_CH'(HALF);
        for (int c = 0; c < HALF; c++) begin
            if (stb[c]) begin
                res_a  = res[c];
                chan_a = W_CH'(c);
            end
            if (stb[c+HALF]) begin
                res_b  = res[c+HALF];
                chan_b = W_CH'(c + HALF);
            end
        end
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) state <= IDLE;
        else          state <= state_nxt;
    end

    // Priority: held result, then bus A, then bus B; the first loser is parked, a second is dropped.
    always_comb begin
        state_nxt = state;
        out_vld   = 1'b0;
        out_dat   = pend_dat;
        out_chan  = pend_chan;
        ld_pend   = 1'b0;
        ld_dat    = res_b;
        ld_chan   = chan_b;
        drop      = 1'b0;
        case (state)
            IDLE: begin
                if (done_a) begin
                    out_vld  = 1'b1;
                    out_dat  = res_a;
                    out_chan = chan_a;
                    if (done_b) begin
                        ld_pend   = 1'b1;
                        state_nxt = PEND;
                    end
                end else if (done_b) begin
                    out_vld  = 1'b1;
                    out_dat  = res_b;
                    out_chan = chan_b;
                end
            end
            PEND: begin
                out_vld = 1'b1;
                if (done_a) begin
                    ld_pend = 1'b1;
                    ld_dat  = res_a;
                    ld_chan = chan_a;
                    drop    = done_b;
                end else if (done_b) begin
                    ld_pend = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (bus.update_in) begin
            state_nxt = IDLE;
            out_vld   = 1'b0;
            ld_pend   = 1'b0;
            drop      = 1'b0;
        end
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            avg_log   <= '0;
            data_q    <= '0;
            chan_q    <= '0;
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
            pend_dat  <= '0;
            pend_chan <= '0;
            for (int c = 0; c < N_CHAN; c++) begin
                acc[c] <= '0;
                cnt[c] <= '0;
            end
        end else begin
            valid_q <= out_vld;
            if (out_vld) begin
                data_q <= out_dat;
                chan_q <= out_chan;
            end
            if (ld_pend) begin
                pend_dat  <= ld_dat;
                pend_chan <= ld_chan;
            end
            if (bus.update_in) begin
                avg_log <= bus.avg_log_in;
                ovf_q   <= 1'b0;
            end else if (drop) begin
                ovf_q <= 1'b1;
            end
            for (int c = 0; c < N_CHAN; c++) begin
                if (bus.update_in || done[c]) begin
                    acc[c] <= '0;
                    cnt[c] <= '0;
                end else if (stb[c]) begin
                    acc[c] <= sum[c];
                    cnt[c] <= cnt[c] + 1'b1;
                end
            end
        end
    end

    assign bus.data_out       = data_q;
    assign bus.chan_out       = chan_q;
    assign bus.data_valid_out = valid_q;
    assign bus.overflow_out   = ovf_q;
endmodule

// File: tb/tb_adc_chan_avg.sv
// Scoreboard bench for adc_chan_avg: expected results (channel, value, cycle) are queued
// as stimulus is driven and matched against the observed output stream per scenario.
module tb_adc_chan_avg;
    typedef struct packed {
        logic [2:0]  chan;
        logic [17:0] data;
        logic [31:0] cyc;
    } rec_t;

    logic clk_in   = 1'b0;
    logic reset_in = 1'b1;
    int   checks   = 0;
    int   errors   = 0;
    int   cyc      = 0;
    rec_t exp_q[$];
    rec_t obs_q[$];
    rec_t e, o;

    adc_chan_avg_if bus ();

    adc_chan_avg dut (
        .clk_in  (clk_in),
        .reset_in(reset_in),
        .bus     (bus)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    always @(negedge clk_in) begin
        if (!reset_in && bus.data_valid_out)
            obs_q.push_back(rec_t'{chan: bus.chan_out, data: bus.data_out, cyc: 32'(cyc)});
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic strobe(input logic [5:0] v, input logic [17:0] a, input logic [17:0] b);
        bus.data_valid_in = v;
        bus.data_a_in     = a;
        bus.data_b_in     = b;
        idle(1);
        bus.data_valid_in = '0;
    endtask

    task automatic set_log(input logic [2:0] n);
        bus.update_in  = 1'b1;
        bus.avg_log_in = n;
        idle(1);
        bus.update_in  = 1'b0;
    endtask

    task automatic expect_out(input logic [2:0] ch, input logic [17:0] d, input int c);
        exp_q.push_back(rec_t'{chan: ch, data: d, cyc: 32'(c)});
    endtask

    task automatic test_reset;
        idle(2);
        checks += 4;
        if (bus.data_out !== 18'd0) begin errors++; $display("FAIL reset_data got %h expected 0", bus.data_out); end
        if (bus.chan_out !== 3'd0) begin errors++; $display("FAIL reset_chan got %0d expected 0", bus.chan_out); end
        if (bus.data_valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got %b expected 0", bus.data_valid_out); end
        if (bus.overflow_out !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b expected 0", bus.overflow_out); end
        reset_in = 1'b0;
        idle(1);
    endtask

    task automatic test_passthrough;
        int n;
        n = cyc;
        strobe(6'b001001, 18'd1111, 18'd4444);
        expect_out(3'd0, 18'd1111, n + 1);
        expect_out(3'd3, 18'd4444, n + 2);
        idle(6);
        checks += 2;
        if (bus.data_out !== 18'd4444) begin errors++; $display("FAIL hold_data got %0d expected 4444", bus.data_out); end
        if (bus.chan_out !== 3'd3) begin errors++; $display("FAIL hold_chan got %0d expected 3", bus.chan_out); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL passthrough missing chan=%0d data=%0d", e.chan, e.data); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin errors++; $display("FAIL passthrough got ch=%0d d=%0d cyc=%0d expected ch=%0d d=%0d cyc=%0d", o.chan, o.data, o.cyc, e.chan, e.data, e.cyc); end
            end
        end
        checks++;
        if (obs_q.size() !== 0) begin errors++; $display("FAIL passthrough extra outputs %0d expected 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_average;
        int n;
        logic [17:0] v[4] = '{18'd2220, 18'd2222, 18'd2224, 18'd2226};
        set_log(3'd2);
        for (int i = 0; i < 4; i++) begin
            n = cyc;
            strobe(6'b000010, v[i], 18'd0);
            if (i < 3) idle(2);
        end
        expect_out(3'd1, 18'd2223, n + 1);
        // Signed floor: (-3 + -4) / 2 rounds down to -4.
        set_log(3'd1);
        strobe(6'b100000, 18'd0, 18'h3FFFD);
        n = cyc;
        strobe(6'b100000, 18'd0, 18'h3FFFC);
        expect_out(3'd5, 18'h3FFFC, n + 1);
        idle(5);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL average missing chan=%0d data=%h", e.chan, e.data); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin errors++; $display("FAIL average got ch=%0d d=%h cyc=%0d expected ch=%0d d=%h cyc=%0d", o.chan, o.data, o.cyc, e.chan, e.data, e.cyc); end
            end
        end
        checks++;
        if (obs_q.size() !== 0) begin errors++; $display("FAIL average extra outputs %0d expected 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_six_chan;
        int n;
        logic [5:0]  vl[3] = '{6'b001001, 6'b010010, 6'b100100};
        logic [17:0] da[3] = '{18'd1111, 18'd2222, 18'd3333};
        logic [17:0] db[3] = '{18'd4444, 18'd5555, 18'd6666};
        set_log(3'd0);
        for (int i = 0; i < 3; i++) begin
            n = cyc;
            strobe(vl[i], da[i], db[i]);
            expect_out(3'(i), da[i], n + 1);
            expect_out(3'(i + 3), db[i], n + 2);
            idle(17);
        end
        checks++;
        if (bus.overflow_out !== 1'b0) begin errors++; $display("FAIL six_chan_ovf got %b expected 0", bus.overflow_out); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL six_chan missing chan=%0d data=%0d", e.chan, e.data); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin errors++; $display("FAIL six_chan got ch=%0d d=%0d cyc=%0d expected ch=%0d d=%0d cyc=%0d", o.chan, o.data, o.cyc, e.chan, e.data, e.cyc); end
            end
        end
        checks++;
        if (obs_q.size() !== 0) begin errors++; $display("FAIL six_chan extra outputs %0d expected 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_update_mid;
        int n;
        set_log(3'd3);
        strobe(6'b000100, 18'd500, 18'd0);
        strobe(6'b000100, 18'd600, 18'd0);
        bus.update_in     = 1'b1;
        bus.avg_log_in    = 3'd1;
        bus.data_valid_in = 6'b000100;
        bus.data_a_in     = 18'd999;
        idle(1);
        bus.update_in     = 1'b0;
        bus.data_valid_in = '0;
        strobe(6'b000100, 18'd10, 18'd0);
        n = cyc;
        strobe(6'b000100, 18'd20, 18'd0);
        expect_out(3'd2, 18'd15, n + 1);
        idle(5);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL update_mid missing chan=%0d data=%0d", e.chan, e.data); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin errors++; $display("FAIL update_mid got ch=%0d d=%0d cyc=%0d expected ch=%0d d=%0d cyc=%0d", o.chan, o.data, o.cyc, e.chan, e.data, e.cyc); end
            end
        end
        checks++;
        if (obs_q.size() !== 0) begin errors++; $display("FAIL update_mid extra outputs %0d expected 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_malformed;
        int n;
        set_log(3'd1);
        // Bits 0 and 1 together: only channel 0 accumulates.
        strobe(6'b000011, 18'd100, 18'd0);
        n = cyc;
        strobe(6'b000011, 18'd100, 18'd0);
        expect_out(3'd0, 18'd100, n + 1);
        // Channel 1 must still be at an empty window.
        strobe(6'b000010, 18'd50, 18'd0);
        n = cyc;
        strobe(6'b000010, 18'd70, 18'd0);
        expect_out(3'd1, 18'd60, n + 1);
        // Upper half 6'b110xxx: only channel 4 is honoured.
        set_log(3'd0);
        n = cyc;
        strobe(6'b110110, 18'd5, 18'd7);
        expect_out(3'd1, 18'd5, n + 1);
        expect_out(3'd4, 18'd7, n + 2);
        idle(5);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL malformed missing chan=%0d data=%0d", e.chan, e.data); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin errors++; $display("FAIL malformed got ch=%0d d=%0d cyc=%0d expected ch=%0d d=%0d cyc=%0d", o.chan, o.data, o.cyc, e.chan, e.data, e.cyc); end
            end
        end
        checks++;
        if (obs_q.size() !== 0) begin errors++; $display("FAIL malformed extra outputs %0d expected 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_overflow;
        int n;
        set_log(3'd0);
        n = cyc;
        strobe(6'b001001, 18'd1, 18'd2);
        strobe(6'b001001, 18'd3, 18'd4);
        strobe(6'b000001, 18'd5, 18'd0);
        // The second B result (4) finds the slot occupied and is lost.
        expect_out(3'd0, 18'd1, n + 1);
        expect_out(3'd3, 18'd2, n + 2);
        expect_out(3'd0, 18'd3, n + 3);
        expect_out(3'd0, 18'd5, n + 4);
        idle(8);
        checks++;
        if (bus.overflow_out !== 1'b1) begin errors++; $display("FAIL overflow_set got %b expected 1", bus.overflow_out); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL overflow missing chan=%0d data=%0d", e.chan, e.data); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin errors++; $display("FAIL overflow got ch=%0d d=%0d cyc=%0d expected ch=%0d d=%0d cyc=%0d", o.chan, o.data, o.cyc, e.chan, e.data, e.cyc); end
            end
        end
        checks++;
        if (obs_q.size() !== 0) begin errors++; $display("FAIL overflow extra outputs %0d expected 0", obs_q.size()); obs_q.delete(); end
        set_log(3'd0);
        checks++;
        if (bus.overflow_out !== 1'b0) begin errors++; $display("FAIL overflow_clear got %b expected 0", bus.overflow_out); end
    endtask

    task automatic test_reset_mid;
        int n;
        set_log(3'd2);
        strobe(6'b000001, 18'd100, 18'd0);
        strobe(6'b000001, 18'd200, 18'd0);
        reset_in = 1'b1;
        idle(1);
        checks += 2;
        if (bus.data_out !== 18'd0) begin errors++; $display("FAIL reset_mid_data got %0d expected 0", bus.data_out); end
        if (bus.chan_out !== 3'd0) begin errors++; $display("FAIL reset_mid_chan got %0d expected 0", bus.chan_out); end
        reset_in = 1'b0;
        idle(1);
        // Depth is back to 0, so a fresh sample passes straight through.
        n = cyc;
        strobe(6'b000001, 18'd40, 18'd0);
        expect_out(3'd0, 18'd40, n + 1);
        idle(5);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL reset_mid missing chan=%0d data=%0d", e.chan, e.data); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin errors++; $display("FAIL reset_mid got ch=%0d d=%0d cyc=%0d expected ch=%0d d=%0d cyc=%0d", o.chan, o.data, o.cyc, e.chan, e.data, e.cyc); end
            end
        end
        checks++;
        if (obs_q.size() !== 0) begin errors++; $display("FAIL reset_mid extra outputs %0d expected 0", obs_q.size()); obs_q.delete(); end
    endtask

    initial begin
        bus.data_valid_in = '0;
        bus.data_a_in     = '0;
        bus.data_b_in     = '0;
        bus.avg_log_in    = '0;
        bus.update_in     = 1'b0;
        @(posedge clk_in);
        #1;
        test_reset;
        test_passthrough;
        test_average;
        test_six_chan;
        test_update_mid;
        test_malformed;
        test_overflow;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
